mdc_stage_commutator: RTL

MDC_STAGE_COMMUTATOR -- requirements
Module: mdc_stage_commutator

---
 rtl/mdc_fft_pkg.sv | 23 ++
 rtl/mdc_stage_commutator_if.sv | 29 ++
 rtl/mdc_delay_line.sv | 39 +++
 rtl/mdc_stage_commutator.sv | 115 +++++++++++
 4 files changed

// File: rtl/mdc_fft_pkg.sv
// Shared constants for the 32-point MDC FFT: sample width, per-stage delays, clog2 helper.
package mdc_fft_pkg;

    localparam int MDC_WIDTH    = 9;
    localparam int MDC_DELAY_S0 = 16;
    localparam int MDC_DELAY_S1 = 8;
    localparam int MDC_DELAY_S2 = 4;
    localparam int MDC_DELAY_S3 = 2;
    localparam int MDC_DELAY_S4 = 1;

    function automatic int mdc_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdc_stage_commutator_if.sv
// Sample-pair stream into and out of one MDC commutator stage.
interface mdc_stage_commutator_if
    import mdc_fft_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH
);

    logic                    in_valid;
    logic signed [WIDTH-1:0] up_in_re;
    logic signed [WIDTH-1:0] up_in_im;
    logic signed [WIDTH-1:0] low_in_re;
    logic signed [WIDTH-1:0] low_in_im;
    logic                    out_valid;
    logic signed [WIDTH-1:0] up_out_re;
    logic signed [WIDTH-1:0] up_out_im;
    logic signed [WIDTH-1:0] low_out_re;
    logic signed [WIDTH-1:0] low_out_im;

    modport master (
        output in_valid, up_in_re, up_in_im, low_in_re, low_in_im,
        input  out_valid, up_out_re, up_out_im, low_out_re, low_out_im
    );

    modport slave (
        input  in_valid, up_in_re, up_in_im, low_in_re, low_in_im,
        output out_valid, up_out_re, up_out_im, low_out_re, low_out_im
    );

endinterface

// File: rtl/mdc_delay_line.sv
// Enable-gated complex shift register; tail is the input from DEPTH accepted samples ago.
module mdc_delay_line
    import mdc_fft_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH,
    parameter int DEPTH = MDC_DELAY_S1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic signed [WIDTH-1:0] i_re,
    input  logic signed [WIDTH-1:0] i_im,
    output logic signed [WIDTH-1:0] o_re,
    output logic signed [WIDTH-1:0] o_im
);

    logic signed [WIDTH-1:0] r_re [DEPTH];
    logic signed [WIDTH-1:0] r_im [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else if (i_en) begin
            r_re[0] <= i_re;
            r_im[0] <= i_im;
            for (int i = 1; i < DEPTH; i++) begin
                r_re[i] <= r_re[i-1];
                r_im[i] <= r_im[i-1];
            end
        end
    end

    assign o_re = r_re[DEPTH-1];
    assign o_im = r_im[DEPTH-1];

endmodule

// File: rtl/mdc_stage_commutator.sv
// MDC stage commutator: delay/switch/delay with registered butterfly-aligned outputs.
// Optional synchronous flush port enabled by defining MDC_COMM_FLUSH_EN.
module mdc_stage_commutator
    import mdc_fft_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH,
    parameter int DELAY = MDC_DELAY_S1
) (
    input  logic clk,
    input  logic rst,
`ifdef MDC_COMM_FLUSH_EN
    input  logic flush,
`endif
    mdc_stage_commutator_if.slave io
);

    localparam int CNT_W   = mdc_clog2(DELAY) + 1;
    localparam int PRIME_W = mdc_clog2(2 * DELAY) + 1;
    localparam logic [PRIME_W-1:0] PRIME_FULL = PRIME_W'(2 * DELAY);

    logic [CNT_W-1:0]        r_cnt;
    logic [PRIME_W-1:0]      r_prime;
    logic                    w_flush;
    logic                    w_accept;
    logic                    w_sel;
    logic                    w_primed;
    logic signed [WIDTH-1:0] w_ud_re, w_ud_im, w_ld_re, w_ld_im;
    logic signed [WIDTH-1:0] w_ld_in_re, w_ld_in_im, w_sw_up_re, w_sw_up_im;
    logic                    r_vld_p1;
    logic signed [WIDTH-1:0] r_up_re_p1, r_up_im_p1, r_low_re_p1, r_low_im_p1;

`ifdef MDC_COMM_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_accept = io.in_valid & ~w_flush;
    // cnt wraps naturally at 2*DELAY; its MSB marks the cross half of each frame
    assign w_sel    = r_cnt[CNT_W-1];
    assign w_primed = (r_prime >= PRIME_FULL);

    always_comb begin
        w_sw_up_re = w_ud_re;
        w_sw_up_im = w_ud_im;
        w_ld_in_re = io.low_in_re;
        w_ld_in_im = io.low_in_im;
        if (w_sel) begin
            w_sw_up_re = io.low_in_re;
            w_sw_up_im = io.low_in_im;
            w_ld_in_re = w_ud_re;
            w_ld_in_im = w_ud_im;
        end
    end

    mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY)) u_ud (
        .clk (clk),
        .rst (rst),
        .i_en(w_accept),
        .i_re(io.up_in_re),
        .i_im(io.up_in_im),
        .o_re(w_ud_re),
        .o_im(w_ud_im)
    );

    mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY)) u_ld (
        .clk (clk),
        .rst (rst),
        .i_en(w_accept),
        .i_re(w_ld_in_re),
        .i_im(w_ld_in_im),
        .o_re(w_ld_re),
        .o_im(w_ld_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_prime  <= '0;
            r_vld_p1 <= 1'b0;
        end else if (w_flush) begin
            r_cnt    <= '0;
            r_prime  <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept & w_primed;
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (!w_primed) r_prime <= r_prime + PRIME_W'(1);
            end
        end
    end

    // output stage p1: loads on the same edge as the delay-line shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_re_p1  <= '0;
            r_up_im_p1  <= '0;
            r_low_re_p1 <= '0;
            r_low_im_p1 <= '0;
        end else if (w_accept) begin
            r_up_re_p1  <= w_sw_up_re;
            r_up_im_p1  <= w_sw_up_im;
            r_low_re_p1 <= w_ld_re;
            r_low_im_p1 <= w_ld_im;
        end
    end

    assign io.out_valid  = r_vld_p1;
    assign io.up_out_re  = r_up_re_p1;
    assign io.up_out_im  = r_up_im_p1;
    assign io.low_out_re = r_low_re_p1;
    assign io.low_out_im = r_low_im_p1;

endmodule
